// File: rtl/seg_pkg.sv
//------------------------------------------------------------------------------
// Module      : seg_pkg
// Description : Shared 7-segment pattern constants and helpers for seg_scan.
//               Bit order of a pattern is {g,f,e,d,c,b,a}, active-high.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package seg_pkg;

  typedef logic [6:0] seg7_t;

  // Standard digit glyphs
  localparam seg7_t SEG_0     = 7'h3F;
  localparam seg7_t SEG_1     = 7'h06;
  localparam seg7_t SEG_2     = 7'h5B;
  localparam seg7_t SEG_3     = 7'h4F;
  localparam seg7_t SEG_4     = 7'h66;
  localparam seg7_t SEG_5     = 7'h6D;
  localparam seg7_t SEG_6     = 7'h7D;
  localparam seg7_t SEG_7     = 7'h07;
  localparam seg7_t SEG_8     = 7'h7F;
  localparam seg7_t SEG_9     = 7'h6F;

  // Non-decimal codes show a dash; blank turns every segment off
  localparam seg7_t SEG_DASH  = 7'h40;
  localparam seg7_t SEG_BLANK = 7'h00;

  // Pack decimal point and glyph into the {dp,g,f,e,d,c,b,a} output byte
  function automatic logic [7:0] seg_byte(input logic dp, input seg7_t segs);
    return {dp, segs};
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_decode.sv
//------------------------------------------------------------------------------
// Module      : seg_decode
// Description : Combinational 4-bit value to 7-segment glyph decoder.
//               0-9 map to standard glyphs, 10-15 map to a dash.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] value,
  output seg7_t      segs
);

  // Glyph lookup; anything outside 0-9 renders as "-"
  always_comb begin
    segs = SEG_DASH;
    case (value)
      4'd0:    segs = SEG_0;
      4'd1:    segs = SEG_1;
      4'd2:    segs = SEG_2;
      4'd3:    segs = SEG_3;
      4'd4:    segs = SEG_4;
      4'd5:    segs = SEG_5;
      4'd6:    segs = SEG_6;
      4'd7:    segs = SEG_7;
      4'd8:    segs = SEG_8;
      4'd9:    segs = SEG_9;
      default: segs = SEG_DASH;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan.sv
//------------------------------------------------------------------------------
// Module      : seg_scan
// Description : Multiplexed 7-segment display scanner. Time-slices DIGITS
//               digits, blanks the anodes at the start of every slot to avoid
//               ghosting, blinks selected digits, and double-buffers the
//               displayed value so updates only land on frame boundaries.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS    = 6,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK     = 16,   // must satisfy 1 <= BLANK < SCAN_DIV
  parameter int BLINK_DIV = 83
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  load,
  output logic [DIGITS-1:0]     seg_an,
  output logic [7:0]            seg_out,
  output logic                  frame_done
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int IDX_W   = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;
  localparam int FRAME_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // Scan position and blink timing
  logic [SCAN_W-1:0]   scan_cnt;
  logic [IDX_W-1:0]    digit_idx;
  logic [FRAME_W-1:0]  frame_cnt;
  logic                blink_phase;

  // Double-buffered display content
  logic [4*DIGITS-1:0] pend_bcd;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_valid;
  logic [4*DIGITS-1:0] disp_bcd;
  logic [DIGITS-1:0]   disp_dp;

  // Combinational view of the current slot
  logic                scan_last;
  logic                digit_last;
  logic                frame_wrap;
  logic                in_blank;
  logic [3:0]          cur_bcd;
  logic                cur_dp;
  logic                cur_blink;
  logic [DIGITS-1:0]   cur_onehot;
  logic                dark;
  seg7_t               dec_segs;

  assign scan_last  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign digit_last = (digit_idx == IDX_W'(DIGITS - 1));
  assign frame_wrap = scan_last && digit_last;
  assign in_blank   = (scan_cnt < SCAN_W'(BLANK));

  // Select the active digit's value, dp, blink enable and anode bit
  always_comb begin
    cur_bcd    = 4'd0;
    cur_dp     = 1'b0;
    cur_blink  = 1'b0;
    cur_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        cur_bcd       = disp_bcd[4*i +: 4];
        cur_dp        = disp_dp[i];
        cur_blink     = blink_mask[i];
        cur_onehot[i] = 1'b1;
      end
    end
  end

  // Slot is dark during the anti-ghost window or when its digit is blinked off
  assign dark = in_blank || (blink_phase && cur_blink);

  seg_decode u_seg_decode (
    .value (cur_bcd),
    .segs  (dec_segs)
  );

  // Scan counter, digit index, frame counter and blink phase
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt    <= '0;
      digit_idx   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (scan_last) begin
        scan_cnt  <= '0;
        digit_idx <= digit_last ? '0 : digit_idx + IDX_W'(1);
      end else begin
        scan_cnt  <= scan_cnt + SCAN_W'(1);
      end
      if (frame_wrap) begin
        if (frame_cnt == FRAME_W'(BLINK_DIV - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt   <= frame_cnt + FRAME_W'(1);
        end
      end
    end
  end

  // Pending/display buffers: display only changes at a frame wrap (tear-free)
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_bcd   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      disp_bcd   <= '0;
      disp_dp    <= '0;
    end else if (load && frame_wrap) begin
      // Load on the wrap itself goes straight to the display; nothing left pending
      pend_bcd   <= bcd_in;
      pend_dp    <= dp_in;
      disp_bcd   <= bcd_in;
      disp_dp    <= dp_in;
      pend_valid <= 1'b0;
    end else if (load) begin
      // Later loads in the same frame simply overwrite earlier ones
      pend_bcd   <= bcd_in;
      pend_dp    <= dp_in;
      pend_valid <= 1'b1;
    end else if (frame_wrap && pend_valid) begin
      disp_bcd   <= pend_bcd;
      disp_dp    <= pend_dp;
      pend_valid <= 1'b0;
    end
  end

  // Registered outputs, one cycle behind the scan state
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_an     <= '0;
      seg_out    <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
      if (dark) begin
        seg_an  <= '0;
        seg_out <= seg_byte(1'b0, SEG_BLANK);
      end else begin
        seg_an  <= cur_onehot;
        seg_out <= seg_byte(cur_dp, dec_segs);
      end
    end
  end

endmodule

`default_nettype wire
